// File: rtl/br_tag_ctrl_pkg.sv
// br_tag_ctrl_pkg -- shared branch-tag mask width and one-hot tag types.
// Rev 1.0
`default_nettype none

`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif

package br_tag_ctrl_pkg;

  localparam int BR_NUM_DEF = `BR_MASK_W;

  typedef logic [`BR_MASK_W-1:0] br_mask_t;
  // A tag is one-hot in a mask-wide vector; all-zero means "no tag".
  typedef br_mask_t br_tag_t;

  localparam br_tag_t BR_TAG_NONE = '0;

endpackage

`default_nettype wire

// File: rtl/br_tag_pe.sv
// br_tag_pe -- one-hot lowest-set-bit priority encoder for free-tag selection.
// Rev 1.0
`default_nettype none

module br_tag_pe
  import br_tag_ctrl_pkg::*;
#(
  parameter int N = BR_NUM_DEF
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_1hot
);

  // Two's-complement isolate of the least significant set bit.
  assign o_1hot = i_req & (~i_req + N'(1));

endmodule

`default_nettype wire

// File: rtl/br_tag_ctrl.sv
// br_tag_ctrl -- branch-tag allocator, dependency tracker and clear/recovery broadcaster.
// Rev 1.0; optional resolve counters under BR_TAG_PERF_EN.
`default_nettype none

module br_tag_ctrl
  import br_tag_ctrl_pkg::*;
#(
  parameter int BR_NUM = BR_NUM_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    disp_br_req_i,
  output logic                    disp_br_gnt_o,
  output logic                    disp_br_stall_o,
  output logic [BR_NUM-1:0]       disp_br_tag_1hot_o,
  output logic [BR_NUM-1:0]       disp_br_mask_o,
  input  logic                    fu_br_right_i,
  input  logic                    fu_br_wrong_i,
  input  logic [BR_NUM-1:0]       fu_br_tag_1hot_i,
  output logic                    br_clear_o,
  output logic [BR_NUM-1:0]       br_clear_1hot_o,
  output logic                    br_recovery_o,
  output logic [BR_NUM-1:0]       br_tag_fix_o,
  output logic [$clog2(BR_NUM):0] free_cnt_o
`ifdef BR_TAG_PERF_EN
  ,
  output logic [31:0]             perf_br_right_cnt_o,
  output logic [31:0]             perf_br_wrong_cnt_o
`endif
);

  localparam int CNT_W = $clog2(BR_NUM) + 1;

  logic [BR_NUM-1:0] r_valid;
  logic [BR_NUM-1:0] r_dep [BR_NUM];

  logic [BR_NUM-1:0] w_free;
  logic [BR_NUM-1:0] w_pe_1hot;
  logic [BR_NUM-1:0] w_alloc;
  logic [BR_NUM-1:0] w_right_1hot;
  logic [BR_NUM-1:0] w_dep_col;
  logic [BR_NUM-1:0] w_squash;
  logic              w_any_free;
  logic              w_gnt;
  logic              w_right_acc;
  logic              w_wrong_acc;
  logic [CNT_W-1:0]  w_busy_cnt;

  assign w_free     = ~r_valid;
  assign w_any_free = |w_free;

  br_tag_pe #(.N(BR_NUM)) u_pe (
    .i_req  (w_free),
    .o_1hot (w_pe_1hot)
  );

  // No grant while in reset or during the two front-end redirect cycles.
  assign w_gnt   = rst & disp_br_req_i & w_any_free & ~fu_br_wrong_i & ~br_recovery_o;
  assign w_alloc = w_gnt ? w_pe_1hot : BR_NUM'(BR_TAG_NONE);

  assign disp_br_gnt_o      = w_gnt;
  assign disp_br_stall_o    = rst & disp_br_req_i & ~w_any_free;
  assign disp_br_tag_1hot_o = w_alloc;
  assign disp_br_mask_o     = r_valid;

  // Resolves on tags that are no longer outstanding are dropped silently.
  assign w_right_acc  = fu_br_right_i & (|(fu_br_tag_1hot_i & r_valid));
  assign w_wrong_acc  = fu_br_wrong_i & (|(fu_br_tag_1hot_i & r_valid));
  assign w_right_1hot = w_right_acc ? fu_br_tag_1hot_i : '0;

  always_comb begin
    w_dep_col  = '0;
    w_busy_cnt = '0;
    for (int i = 0; i < BR_NUM; i++) begin
      w_dep_col[i] = |(r_dep[i] & fu_br_tag_1hot_i);
      w_busy_cnt   = w_busy_cnt + CNT_W'(r_valid[i]);
    end
  end

  assign w_squash   = w_wrong_acc ? (fu_br_tag_1hot_i | (w_dep_col & r_valid)) : '0;
  assign free_cnt_o = CNT_W'(BR_NUM) - w_busy_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid         <= '0;
      br_clear_o      <= 1'b0;
      br_clear_1hot_o <= '0;
      br_recovery_o   <= 1'b0;
      br_tag_fix_o    <= '0;
      for (int i = 0; i < BR_NUM; i++) begin
        r_dep[i] <= '0;
      end
    end else begin
      r_valid <= (r_valid & ~w_right_1hot & ~w_squash) | w_alloc;
      // A tag freed this cycle must not appear as an ancestor of the new tag.
      for (int i = 0; i < BR_NUM; i++) begin
        if (w_alloc[i]) begin
          r_dep[i] <= r_valid & ~w_right_1hot;
        end else begin
          r_dep[i] <= r_dep[i] & ~w_right_1hot;
        end
      end
      br_clear_o      <= w_right_acc;
      br_clear_1hot_o <= w_right_1hot;
      br_recovery_o   <= w_wrong_acc;
      br_tag_fix_o    <= w_squash;
    end
  end

`ifdef BR_TAG_PERF_EN
  logic [31:0] r_perf_right;
  logic [31:0] r_perf_wrong;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_right <= '0;
      r_perf_wrong <= '0;
    end else begin
      if (w_right_acc) r_perf_right <= r_perf_right + 32'd1;
      if (w_wrong_acc) r_perf_wrong <= r_perf_wrong + 32'd1;
    end
  end

  assign perf_br_right_cnt_o = r_perf_right;
  assign perf_br_wrong_cnt_o = r_perf_wrong;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) begin
      assert (!(fu_br_right_i && fu_br_wrong_i));
      if (fu_br_right_i || fu_br_wrong_i) begin
        assert ($onehot(fu_br_tag_1hot_i));
      end
    end
  end
`endif

endmodule

`default_nettype wire
